// File: rtl/ustc_psum_ctrl_if.sv
// Stream and column-buffer signals of the partial-sum sequencer.
// Handshake: a beat transfers on a rising edge where in_valid and in_ready are both 1;
// in_valid never waits on in_ready, and the beat fields hold steady while in_valid is 1.
interface ustc_psum_ctrl_if #(
  parameter int NUM_IN  = 32,
  parameter int DW_LINE = 14,
  parameter int DW_COL  = 4
);
  logic                      in_valid;
  logic                      in_ready;
  logic [NUM_IN*DW_LINE-1:0] in_data;
  logic [DW_COL-1:0]         in_col;
  logic                      in_last;
  logic                      buf_input_en;
  logic                      buf_output_en;
  logic [DW_COL-1:0]         buf_col;
  logic [NUM_IN*DW_LINE-1:0] buf_in;
  logic                      buf_out_valid;

  // The environment side: upstream producer plus the column buffer.
  modport master (
    output in_valid, in_data, in_col, in_last, buf_out_valid,
    input  in_ready, buf_input_en, buf_output_en, buf_col, buf_in
  );

  modport slave (
    input  in_valid, in_data, in_col, in_last, buf_out_valid,
    output in_ready, buf_input_en, buf_output_en, buf_col, buf_in
  );
endinterface

// File: rtl/ustc_psum_ctrl.sv
// Tile sequencer for the sparse partial-sum column buffer: forward, flush, drain.
// Optional drain watchdog: define USTC_PSUM_CTRL_TIMEOUT_EN (adds parameter TIMEOUT_CYC).
module ustc_psum_ctrl #(
  parameter int NUM_IN    = 32,
  parameter int DW_LINE   = 14,
  parameter int DW_COL    = 4,
  parameter int FLUSH_CYC = 2
`ifdef USTC_PSUM_CTRL_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 64
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  ustc_psum_ctrl_if.slave      bus,
  output logic                 tile_done,
  output logic [15:0]          beat_cnt,
  output logic                 err_order,
  output logic                 err_timeout,
  output logic [2:0]           state_dbg
);

  localparam int DW_BUS = NUM_IN * DW_LINE;
  localparam int FC_W   = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [FC_W-1:0] FLUSH_LAST = FC_W'(FLUSH_CYC - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACCUM = 3'd1,
    FLUSH = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t              state;
  logic [DW_COL-1:0]   cur_col;
  logic [FC_W-1:0]     flush_cnt;
  logic                drain_first;
  logic                input_en_q;
  logic                output_en_q;
  logic [DW_COL-1:0]   col_q;
  logic [DW_BUS-1:0]   data_q;
  logic                accept;
  logic                in_order;

  // Gated by rst so upstream sees no acceptance while the whole block is held in reset.
  assign bus.in_ready      = ~rst & ((state == IDLE) | (state == ACCUM));
  assign accept            = bus.in_valid & bus.in_ready;
  assign in_order          = (bus.in_col >= cur_col);

  assign bus.buf_input_en  = input_en_q;
  assign bus.buf_output_en = output_en_q;
  assign bus.buf_col       = col_q;
  assign bus.buf_in        = data_q;
  assign state_dbg         = state;

`ifdef USTC_PSUM_CTRL_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  logic [TO_W-1:0] drain_cnt;
`else
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cur_col     <= '0;
      flush_cnt   <= '0;
      drain_first <= 1'b0;
      input_en_q  <= 1'b0;
      output_en_q <= 1'b0;
      col_q       <= '0;
      data_q      <= '0;
      tile_done   <= 1'b0;
      beat_cnt    <= '0;
      err_order   <= 1'b0;
`ifdef USTC_PSUM_CTRL_TIMEOUT_EN
      drain_cnt   <= '0;
      err_timeout <= 1'b0;
`endif
    end else begin
      input_en_q  <= 1'b0;
      output_en_q <= 1'b0;
      tile_done   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            input_en_q <= 1'b1;
            col_q      <= bus.in_col;
            data_q     <= bus.in_data;
            cur_col    <= bus.in_col;
            beat_cnt   <= 16'd1;
            flush_cnt  <= '0;
            state      <= bus.in_last ? FLUSH : ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            // Out-of-order beats are swallowed so the buffer never sees a column go backwards.
            if (in_order) begin
              input_en_q <= 1'b1;
              col_q      <= bus.in_col;
              data_q     <= bus.in_data;
              cur_col    <= bus.in_col;
              if (beat_cnt != 16'hFFFF) beat_cnt <= beat_cnt + 16'd1;
            end else begin
              err_order <= 1'b1;
            end
            if (bus.in_last) begin
              flush_cnt <= '0;
              state     <= FLUSH;
            end
          end
        end
        FLUSH: begin
          // Zero beats on the next column make the buffer commit the last open column.
          input_en_q <= 1'b1;
          col_q      <= cur_col + DW_COL'(1);
          data_q     <= '0;
          if (flush_cnt == FLUSH_LAST) begin
            drain_first <= 1'b1;
            state       <= DRAIN;
`ifdef USTC_PSUM_CTRL_TIMEOUT_EN
            drain_cnt   <= '0;
`endif
          end else begin
            flush_cnt <= flush_cnt + FC_W'(1);
          end
        end
        DRAIN: begin
          output_en_q <= drain_first;
          drain_first <= 1'b0;
          if (bus.buf_out_valid) begin
            tile_done <= 1'b1;
            state     <= DONE;
          end
`ifdef USTC_PSUM_CTRL_TIMEOUT_EN
          else if (drain_cnt == TO_LAST) begin
            err_timeout <= 1'b1;
            tile_done   <= 1'b1;
            state       <= DONE;
          end else begin
            drain_cnt <= drain_cnt + TO_W'(1);
          end
`endif
        end
        DONE: begin
          cur_col <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ustc_psum_ctrl.sv
// Directed bench for ustc_psum_ctrl: drivers push expected buffer events, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_ustc_psum_ctrl;
  localparam int NUM_IN      = 32;
  localparam int DW_LINE     = 14;
  localparam int DW_COL      = 4;
  localparam int FLUSH_CYC   = 2;
  localparam int TIMEOUT_CYC = 8;
  localparam int DW          = NUM_IN * DW_LINE;
  localparam int W           = 32 + DW_COL + DW;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_DRAIN = 3'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tile_done;
  logic [15:0] beat_cnt;
  logic        err_order;
  logic        err_timeout;
  logic [2:0]  state_dbg;

  int cyc    = 0;
  int n_vec  = 0;
  int n_err  = 0;
  int last_t = 0;
  logic mon_en = 1'b0;

  logic [W-1:0]  exp_q[$];   // {cycle, col, data} of each expected buffer write
  logic [31:0]   oen_q[$];   // cycle of each expected output_en pulse
  logic [48:0]   done_q[$];  // {cycle, beat_cnt, err_order} of each expected tile_done
  logic [W-1:0]  mon_e;
  logic [48:0]   mon_d;

  ustc_psum_ctrl_if #(.NUM_IN(NUM_IN), .DW_LINE(DW_LINE), .DW_COL(DW_COL)) bus ();

  ustc_psum_ctrl #(
    .NUM_IN(NUM_IN), .DW_LINE(DW_LINE), .DW_COL(DW_COL), .FLUSH_CYC(FLUSH_CYC)
`ifdef USTC_PSUM_CTRL_TIMEOUT_EN
    , .TIMEOUT_CYC(TIMEOUT_CYC)
`endif
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .tile_done(tile_done), .beat_cnt(beat_cnt), .err_order(err_order),
    .err_timeout(err_timeout), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.buf_input_en) begin
        if (exp_q.size() == 0) check("unexpected_input_en", 512'(bus.buf_input_en), 512'(0));
        else begin
          mon_e = exp_q.pop_front();
          check("wr_cycle", 512'(cyc), 512'(mon_e[W-1 -: 32]));
          check("wr_col", 512'(bus.buf_col), 512'(mon_e[DW +: DW_COL]));
          check("wr_data", 512'(bus.buf_in), 512'(mon_e[DW-1:0]));
        end
      end
      if (bus.buf_output_en) begin
        if (oen_q.size() == 0) check("unexpected_output_en", 512'(bus.buf_output_en), 512'(0));
        else check("output_en_cycle", 512'(cyc), 512'(oen_q.pop_front()));
      end
      if (tile_done) begin
        if (done_q.size() == 0) check("unexpected_tile_done", 512'(tile_done), 512'(0));
        else begin
          mon_d = done_q.pop_front();
          check("done_cycle", 512'(cyc), 512'(mon_d[48:17]));
          check("done_beat_cnt", 512'(beat_cnt), 512'(mon_d[16:1]));
          check("done_err_order", 512'(err_order), 512'(mon_d[0]));
        end
      end
    end
  end

  // driver tasks
  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic beat(input logic [DW_COL-1:0] col, input logic last, input logic fwd);
    logic [DW-1:0] d;
    logic rdy;
    int t;
    int tries;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_col   = col;
    bus.in_last  = last;
    rdy   = 1'b0;
    tries = 0;
    t     = 0;
    while (!rdy && tries < 50) begin
      @(negedge clk);
      rdy = bus.in_ready;
      t   = cyc;
      @(posedge clk); #1;
      tries++;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (!rdy) check("accept_timeout", 512'(rdy), 512'(1));
    if (fwd) exp_q.push_back({32'(t + 1), col, d});
    if (last) last_t = t;
  endtask

  task automatic expect_flush(input logic [DW_COL-1:0] fcol);
    for (int i = 0; i < FLUSH_CYC; i++) exp_q.push_back({32'(last_t + 2 + i), fcol, {DW{1'b0}}});
    oen_q.push_back(32'(last_t + 2 + FLUSH_CYC));
  endtask

  task automatic finish_tile(input int delay, input logic [15:0] cnt, input logic err);
    int d;
    d = last_t + 2 + FLUSH_CYC + delay;
    wait_cyc(d);
    bus.buf_out_valid = 1'b1;
    done_q.push_back({32'(d + 1), cnt, err});
    wait_cyc(d + 1);
    bus.buf_out_valid = 1'b0;
    wait_cyc(d + 2);
    check("pending_writes", 512'(exp_q.size()), 512'(0));
    check("pending_done", 512'(done_q.size()), 512'(0));
  endtask

  task automatic check_reset_outputs(input logic exp_ready);
    check("rst_in_ready", 512'(bus.in_ready), 512'(exp_ready));
    check("rst_input_en", 512'(bus.buf_input_en), 512'(0));
    check("rst_output_en", 512'(bus.buf_output_en), 512'(0));
    check("rst_buf_col", 512'(bus.buf_col), 512'(0));
    check("rst_buf_in", 512'(bus.buf_in), 512'(0));
    check("rst_tile_done", 512'(tile_done), 512'(0));
    check("rst_beat_cnt", 512'(beat_cnt), 512'(0));
    check("rst_err_order", 512'(err_order), 512'(0));
    check("rst_err_timeout", 512'(err_timeout), 512'(0));
  endtask

  initial begin
    bus.in_valid      = 1'b0;
    bus.in_data       = '0;
    bus.in_col        = '0;
    bus.in_last       = 1'b0;
    bus.buf_out_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs(1'b0);
    @(posedge clk); #1;
    rst    = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check("idle_in_ready", 512'(bus.in_ready), 512'(1));
    check("idle_state", 512'(state_dbg), 512'(ST_IDLE));
    @(posedge clk); #1;

    // single beat col 3, last: flush col 4, out_valid 5 cycles after output_en
    beat(4'd3, 1'b1, 1'b1);
    expect_flush(4'd4);
    finish_tile(5, 16'd1, 1'b0);

    // cols 0,0,1,2 with gaps
    beat(4'd0, 1'b0, 1'b1);
    gap(2);
    beat(4'd0, 1'b0, 1'b1);
    gap(1);
    beat(4'd1, 1'b0, 1'b1);
    beat(4'd2, 1'b1, 1'b1);
    expect_flush(4'd3);
    finish_tile(2, 16'd4, 1'b0);

    // col 5 then col 2 (last): second beat dropped, order error
    beat(4'd5, 1'b0, 1'b1);
    beat(4'd2, 1'b1, 1'b0);
    expect_flush(4'd6);
    finish_tile(1, 16'd1, 1'b1);

    // col 15: flush column wraps to 0, err_order stays sticky
    beat(4'd15, 1'b1, 1'b1);
    expect_flush(4'd0);
    finish_tile(0, 16'd1, 1'b1);

    // reset in the middle of FLUSH
    beat(4'd7, 1'b1, 1'b1);
    exp_q.push_back({32'(last_t + 2), 4'd8, {DW{1'b0}}});
    gap(1);
    rst = 1'b1;
    gap(1);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs(1'b1);
    check("post_rst_state", 512'(state_dbg), 512'(ST_IDLE));
    @(posedge clk); #1;
    check("post_rst_writes", 512'(exp_q.size()), 512'(0));

    // clean tile after reset
    beat(4'd4, 1'b0, 1'b1);
    beat(4'd9, 1'b1, 1'b1);
    expect_flush(4'd10);
    finish_tile(0, 16'd2, 1'b0);

    // drain with buf_out_valid held low
    beat(4'd2, 1'b1, 1'b1);
    expect_flush(4'd3);
`ifdef USTC_PSUM_CTRL_TIMEOUT_EN
    done_q.push_back({32'(last_t + 1 + FLUSH_CYC + TIMEOUT_CYC), 16'd1, 1'b0});
    wait_cyc(last_t + 3 + FLUSH_CYC + TIMEOUT_CYC);
    check("timeout_flag", 512'(err_timeout), 512'(1));
    check("timeout_state", 512'(state_dbg), 512'(ST_IDLE));
    check("timeout_pending_done", 512'(done_q.size()), 512'(0));
`else
    wait_cyc(last_t + 2 + FLUSH_CYC + 20);
    check("drain_wait_state", 512'(state_dbg), 512'(ST_DRAIN));
    check("drain_wait_timeout", 512'(err_timeout), 512'(0));
    check("drain_wait_ready", 512'(bus.in_ready), 512'(0));
    finish_tile(21, 16'd1, 1'b0);
`endif

    gap(3);
    check("final_writes", 512'(exp_q.size()), 512'(0));
    check("final_output_en", 512'(oen_q.size()), 512'(0));
    check("final_done", 512'(done_q.size()), 512'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
